// File: rtl/onehot_decode_unit.sv
// Position-code to one-hot mask decoder with valid/ready handshakes, a small
// output FIFO, and debug counters for decoded and invalid codes.
module onehot_decode_unit #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_mask,
    output logic             out_zero,
    output logic             out_err,
    output logic [CNT_W-1:0] dec_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] DEPTH_O = OW'(DEPTH);

    typedef struct packed {
        logic [31:0] mask;
        logic        zero;
        logic        err;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]   occ_q, occ_d;
    logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    entry_t dec_ent;
    entry_t head;
    logic   push, pop;

    always_comb begin
        dec_ent = '0;
        if (in_code >= 6'd1 && in_code <= 6'd32) begin
            dec_ent.mask = 32'd1 << (in_code - 6'd1);
        end else if (in_code == 6'd33) begin
            dec_ent.zero = 1'b1;
        end else begin
            dec_ent.err = 1'b1;
        end
    end

    // in_ready depends only on registered occupancy, never on out_ready
    assign in_ready  = !rst && (occ_q < DEPTH_O);
    assign out_valid = (occ_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head      = mem_q[rd_ptr_q];
    assign out_mask  = out_valid ? head.mask : '0;
    assign out_zero  = out_valid ? head.zero : 1'b0;
    assign out_err   = out_valid ? head.err  : 1'b0;
    assign dec_cnt   = dec_cnt_q;
    assign err_cnt   = err_cnt_q;

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        dec_cnt_d = dec_cnt_q;
        err_cnt_d = err_cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = dec_ent;
            wr_ptr_d        = wr_ptr_q + PW'(1);
            dec_cnt_d       = dec_cnt_q + CNT_W'(1);
            if (dec_ent.err && err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        // simultaneous push and pop leaves occupancy unchanged
        case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            dec_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            dec_cnt_q <= dec_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_onehot_decode_unit.sv
// Scoreboard bench for onehot_decode_unit: stimulus queues expected heads,
// a monitor compares them as the FIFO presents them.
module tb_onehot_decode_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [5:0]  in_code;
    logic [31:0] out_mask;
    logic        out_zero, out_err;
    logic [15:0] dec_cnt, err_cnt;

    // narrow-counter instance used to reach counter limits quickly
    logic        s_rst, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [5:0]  s_in_code;
    logic [31:0] s_out_mask;
    logic        s_out_zero, s_out_err;
    logic [3:0]  s_dec_cnt, s_err_cnt;

    int n_cmp = 0;
    int n_fail = 0;
    logic [33:0] sb[$];

    always #5 clk = ~clk;

    onehot_decode_unit #(.DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
        .out_mask(out_mask), .out_zero(out_zero), .out_err(out_err),
        .dec_cnt(dec_cnt), .err_cnt(err_cnt)
    );

    onehot_decode_unit #(.DEPTH(2), .CNT_W(4)) u_small (
        .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_code(s_in_code), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_mask(s_out_mask), .out_zero(s_out_zero), .out_err(s_out_err),
        .dec_cnt(s_dec_cnt), .err_cnt(s_err_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // drive one code for one edge; queue the expectation only if it will be taken
    task automatic send(input logic [5:0] c, input logic [33:0] exp, output logic acc);
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = c;
        acc      = in_ready;
        if (acc) sb.push_back(exp);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk("drain_left", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // monitor: compare head whenever a pop will happen at the next edge
    initial begin
        logic [33:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_head", {out_mask, out_zero, out_err}, 64'h3_FFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("head", {out_mask, out_zero, out_err}, e);
                end
            end
        end
    end

    initial begin
        logic acc;
        rst = 1'b1; in_valid = 1'b0; in_code = 6'd0; out_ready = 1'b1;
        s_rst = 1'b1; s_in_valid = 1'b0; s_in_code = 6'd0; s_out_ready = 1'b1;
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_mask_flags", {out_mask, out_zero, out_err}, 34'd0);
        chk("rst_counters", {dec_cnt, err_cnt}, 32'd0);
        @(negedge clk); rst = 1'b0;

        // 1: simple decodes, one cycle latency
        send(6'd1, {32'h0000_0001, 2'b00}, acc);
        @(negedge clk); #1 chk("lat_1", out_valid, 1'b1);
        send(6'd5, {32'h0000_0010, 2'b00}, acc);
        @(negedge clk); #1 chk("lat_5", out_valid, 1'b1);
        send(6'd32, {32'h8000_0000, 2'b00}, acc);
        @(negedge clk); #1 chk("lat_32", out_valid, 1'b1);
        drain();

        // 2: zero code and invalid codes
        do_reset();
        send(6'd33, {32'h0, 2'b10}, acc);
        send(6'd0,  {32'h0, 2'b01}, acc);
        send(6'd40, {32'h0, 2'b01}, acc);
        drain();
        chk("cnt_dec_3", dec_cnt, 16'd3);
        chk("cnt_err_2", err_cnt, 16'd2);

        // 3: back-pressure until full
        do_reset();
        @(negedge clk); out_ready = 1'b0;
        send(6'd3, {32'h0000_0004, 2'b00}, acc);
        send(6'd4, {32'h0000_0008, 2'b00}, acc);
        @(negedge clk); #1 chk("full_in_ready", in_ready, 1'b0);
        send(6'd7, {32'h0000_0040, 2'b00}, acc);
        chk("full_reject_7", acc, 1'b0);
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); #1 chk("ready_after_pop", in_ready, 1'b1);
        drain();
        chk("cnt_after_full", dec_cnt, 16'd2);

        // 4: push and pop together at occupancy 1
        do_reset();
        @(negedge clk); out_ready = 1'b0;
        send(6'd9, {32'h0000_0100, 2'b00}, acc);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_code   = 6'd10;
        if (in_ready) sb.push_back({32'h0000_0200, 2'b00});
        chk("pp_accept", in_ready, 1'b1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk); #1;
        chk("pp_occ1_ready", in_ready, 1'b1);
        chk("pp_occ1_valid", out_valid, 1'b1);
        @(negedge clk); #1 chk("pp_no_dup", out_valid, 1'b0);
        drain();

        // 5: reset pulse between edges while full
        @(negedge clk); out_ready = 1'b0;
        send(6'd11, {32'h0000_0400, 2'b00}, acc);
        send(6'd12, {32'h0000_0800, 2'b00}, acc);
        @(negedge clk);
        #1 rst = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_cnt", {dec_cnt, err_cnt}, 32'd0);
        chk("mid_rst_ready", in_ready, 1'b0);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk("no_stale", out_valid, 1'b0);
        send(6'd2, {32'h0000_0002, 2'b00}, acc);
        drain();
        chk("cnt_after_rst", dec_cnt, 16'd1);

        // 6: counter limits on the 4-bit instance, streaming code 63
        @(negedge clk);
        s_rst = 1'b0;
        s_in_code = 6'd63;
        s_in_valid = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("sat_err_15", s_err_cnt, 4'hF);
        chk("sat_dec_15", s_dec_cnt, 4'hF);
        chk("sat_head_err", {s_out_mask, s_out_zero, s_out_err}, {32'h0, 2'b01});
        @(posedge clk);
        @(negedge clk);
        chk("sat_err_hold", s_err_cnt, 4'hF);
        chk("wrap_dec_0", s_dec_cnt, 4'h0);
        s_in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
